// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared defaults and FSM state type for the regfile write controller
package regfile_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

  typedef enum logic {ST_INIT, ST_RUN} st_e;
endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, requester 0 favoured after reset
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;  // 1 when requester 1 won the most recent grant

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || last)) gnt = 2'b01;
    else if (req[1])                 gnt = 2'b10;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                last <= 1'b1;
    else if (gnt != 2'b00) last <= gnt[1];
  end
endmodule

// File: rtl/regfile_write_ctrl.sv
// rtl/regfile_write_ctrl.sv - register file write-port controller: zeroing sweep,
// round-robin writeback arbitration and pending-write scoreboard
module regfile_write_ctrl #(
  parameter int DATA_W = regfile_ctrl_pkg::DATA_W,
  parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W,
  parameter int NREG   = regfile_ctrl_pkg::NREG
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              rsv_valid,
  input  logic [ADDR_W-1:0] rsv_reg,
  input  logic [ADDR_W-1:0] regA,
  input  logic [ADDR_W-1:0] regB,
  output logic              hazardA,
  output logic              hazardB,
  output logic [NREG-1:0]   pending,
  output logic              init_done,
  output logic              WS,
  output logic [ADDR_W-1:0] regW,
  output logic [DATA_W-1:0] dataW
);
  import regfile_ctrl_pkg::*;

  st_e               state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              run;
  logic [1:0]        gnt;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  logic              ws_nxt, done_nxt;
  logic [ADDR_W-1:0] regw_nxt;
  logic [DATA_W-1:0] dataw_nxt;
  logic [NREG-1:0]   set_mask, clr_mask, pending_nxt;

  assign run = (state == ST_RUN);

  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({req1_valid & run, req0_valid & run}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign win_reg    = gnt[1] ? req1_reg  : req0_reg;
  assign win_data   = gnt[1] ? req1_data : req0_data;
  assign hazardA    = pending[regA];
  assign hazardB    = pending[regB];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = init_done;
    ws_nxt    = 1'b0;
    regw_nxt  = regW;
    dataw_nxt = dataW;
    set_mask  = '0;
    clr_mask  = '0;
    case (state)
      ST_INIT: begin
        ws_nxt    = 1'b1;
        regw_nxt  = cnt;
        dataw_nxt = '0;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == ADDR_W'(NREG - 1)) begin
          state_nxt = ST_RUN;
          done_nxt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (gnt != 2'b00) begin
          // register 0 is hardwired: the handshake completes but nothing is written
          ws_nxt    = (win_reg != '0);
          regw_nxt  = win_reg;
          dataw_nxt = win_data;
          clr_mask  = NREG'(1) << win_reg;
        end
        if (rsv_valid && rsv_reg != '0) set_mask = NREG'(1) << rsv_reg;
      end
      default: state_nxt = ST_INIT;
    endcase
    // set applied after clear so a same-cycle reserve keeps the bit
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      WS        <= 1'b0;
      regW      <= '0;
      dataW     <= '0;
      pending   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= done_nxt;
      WS        <= ws_nxt;
      regW      <= regw_nxt;
      dataW     <= dataw_nxt;
      pending   <= pending_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// tb/tb_regfile_write_ctrl.sv - scoreboard bench for regfile_write_ctrl
module tb_regfile_write_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [AW-1:0] req0_reg, req1_reg, rsv_reg, regA, regB, regW;
  logic [DW-1:0] req0_data, req1_data, dataW;
  logic          rsv_valid, hazardA, hazardB, init_done, WS;
  logic [NR-1:0] pending;

  regfile_write_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_reg(req0_reg), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_reg(req1_reg), .req1_data(req1_data), .req1_ready(req1_ready),
    .rsv_valid(rsv_valid), .rsv_reg(rsv_reg), .regA(regA), .regB(regB),
    .hazardA(hazardA), .hazardB(hazardB), .pending(pending), .init_done(init_done),
    .WS(WS), .regW(regW), .dataW(dataW)
  );

  always #5 clk = ~clk;

  // register file stand-in, committing on the negedge like the real one
  logic [DW-1:0] rf [NR];
  always @(negedge clk) if (WS) rf[regW] <= dataW;

  typedef struct {
    logic          ws;
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic [NR-1:0] pend;
    logic          done;
    logic          known;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic          m_run, m_last, m_done, m_known;
  logic [AW-1:0] m_cnt, m_reg;
  logic [DW-1:0] m_data;
  logic [NR-1:0] m_pend;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_last = 1'b1; m_done = 1'b0; m_known = 1'b1;
    m_cnt = '0; m_reg = '0; m_data = '0; m_pend = '0;
  endtask

  task automatic step();
    exp_t          e;
    logic          g0, g1, ws;
    logic [AW-1:0] wr;
    @(negedge clk);
    if (rst) begin
      check("rst_WS", WS, 0);
      check("rst_regW", regW, 0);
      check("rst_dataW", dataW, 0);
      check("rst_pending", pending, 0);
      check("rst_init_done", init_done, 0);
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      sb.delete();
      model_reset();
      e = '{1'b0, '0, '0, '0, 1'b0, 1'b1};
      sb.push_back(e);
    end else begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("WS", WS, e.ws);
        if (e.known) begin
          check("regW", regW, e.r);
          check("dataW", dataW, e.d);
        end
        check("pending", pending, e.pend);
        check("init_done", init_done, e.done);
      end
      g0 = m_run && req0_valid && (!req1_valid || m_last);
      g1 = m_run && req1_valid && (!req0_valid || !m_last);
      check("ready0", req0_ready, g0);
      check("ready1", req1_ready, g1);
      check("hazardA", hazardA, m_pend[regA]);
      check("hazardB", hazardB, m_pend[regB]);
      ws = 1'b0;
      if (!m_run) begin
        ws = 1'b1; m_reg = m_cnt; m_data = '0; m_known = 1'b1;
        if (m_cnt == AW'(NR - 1)) begin m_run = 1'b1; m_done = 1'b1; end
        m_cnt = m_cnt + 1'b1;
      end else begin
        if (g0 || g1) begin
          wr = g1 ? req1_reg : req0_reg;
          if (wr != '0) begin
            ws = 1'b1; m_reg = wr; m_data = g1 ? req1_data : req0_data;
            m_known = 1'b1; m_pend[wr] = 1'b0;
          end else m_known = 1'b0;
          m_last = g1;
        end
        if (rsv_valid && rsv_reg != '0) m_pend[rsv_reg] = 1'b1;
      end
      e = '{ws, m_reg, m_data, m_pend, m_done, m_known};
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) rf[i] = 32'hA5A5_0000 | i;
    model_reset();
    req0_valid = 1'b1; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    rsv_valid = 1'b0; rsv_reg = '0; regA = '0; regB = '0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (NR) step();

    req0_reg = 5'd3; req0_data = 32'hDEADBEEF;
    step();
    req0_valid = 1'b0;
    step();
    check("rf3", rf[3], 32'hDEADBEEF);
    check("rf0_swept", rf[0], 0);
    check("rf17_swept", rf[17], 0);
    check("rf31_swept", rf[31], 0);

    req1_valid = 1'b1; req1_reg = 5'd0; req1_data = 32'hFFFFFFFF;
    step();
    req1_valid = 1'b0;
    step();
    check("rf0_hardwired", rf[0], 0);

    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_reg = 5'd2; req1_data = 32'h22;
    repeat (4) step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    rsv_valid = 1'b1; rsv_reg = 5'd5; regA = 5'd5; regB = 5'd6;
    step();
    rsv_valid = 1'b0;
    repeat (3) step();
    req1_valid = 1'b1; req1_reg = 5'd5; req1_data = 32'h55;
    step();
    req1_valid = 1'b0;
    step();
    rsv_valid = 1'b1;
    step();
    rsv_valid = 1'b1; req1_valid = 1'b1; req1_data = 32'h56;
    step();
    rsv_valid = 1'b0; req1_valid = 1'b0;
    step();
    rsv_valid = 1'b1; rsv_reg = 5'd0; regB = 5'd0;
    step();
    rsv_valid = 1'b0;
    step();

    for (int i = 0; i < 40; i++) begin
      req0_valid = $urandom_range(0, 1); req0_reg = AW'($urandom_range(0, NR - 1)); req0_data = $urandom;
      req1_valid = $urandom_range(0, 1); req1_reg = AW'($urandom_range(0, NR - 1)); req1_data = $urandom;
      rsv_valid  = $urandom_range(0, 1); rsv_reg  = AW'($urandom_range(0, NR - 1));
      regA = AW'($urandom_range(0, NR - 1)); regB = AW'($urandom_range(0, NR - 1));
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsv_valid = 1'b0;
    step();

    rst = 1'b1;
    step();
    rst = 1'b0;
    req0_valid = 1'b1;
    repeat (17) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (NR) step();
    step();
    req0_valid = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32x32 register file (`BancoDeRegistradores`). It runs a post-reset sweep that zeroes every register, because the register file has no reset of its own. It then shares the single write port between two writeback requesters (ALU, load unit) with round-robin arbitration. It also keeps a pending-write scoreboard that flags read-after-write hazards on the two read addresses.

## Interface
- `DATA_W`, default 32: write data width.
- `ADDR_W`, default 5: register address width.
- `NREG`, default 32: number of registers; must equal 2**ADDR_W.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_valid` in 1: ALU writeback request.
- `req0_reg` in ADDR_W: destination register for requester 0.
- `req0_data` in DATA_W: write data for requester 0.
- `req0_ready` out 1: grant to requester 0; transfer when valid && ready.
- `req1_valid`, `req1_reg`, `req1_data`, `req1_ready`: same set for the load unit.
- `rsv_valid` in 1: issue stage reserves a destination register.
- `rsv_reg` in ADDR_W: register being reserved.
- `regA`, `regB` in ADDR_W: decode-stage read addresses.
- `hazardA`, `hazardB` out 1: `pending[regA]`, `pending[regB]`, combinational.
- `pending` out NREG: scoreboard bitmap.
- `init_done` out 1: high once the sweep completes.
- `WS` out 1: register file write enable (registered).
- `regW` out ADDR_W: register file write address (registered).
- `dataW` out DATA_W: register file write data (registered).

## Operation
- FSM states: INIT and RUN. Reset enters INIT with the sweep counter at 0.
- INIT, each cycle:
  - Drive `WS`=1, `regW`=counter, `dataW`=0, then increment the counter.
  - After the write to NREG-1 is issued, move to RUN and set `init_done`=1.
  - `req*_ready`=0 throughout.
  - `rsv_valid` is ignored.
- RUN arbitration:
  - At most one grant per cycle; `ready` is combinational from `valid` and the priority pointer.
  - If only one requester is valid, it wins.
  - If both are valid, the one not granted last wins.
  - The pointer updates on every grant. After reset, requester 0 has priority.
- RUN write, on the posedge that ends a grant cycle:
  - `WS`<=1, `regW`<=winner reg, `dataW`<=winner data.
  - With no grant: `WS`<=0; `regW`/`dataW` hold.
  - A write to register 0 is still handshaken and still updates the pointer, but `WS`<=0 (the write is discarded).
- Scoreboard:
  - `rsv_valid` with `rsv_reg`!=0 sets `pending[rsv_reg]`; reserving register 0 is ignored.
  - A granted write clears `pending[reg]` on the same posedge that registers `WS`.
  - If set and clear hit the same register in the same cycle, set wins.
  - `pending[0]` is always 0.
- Reset mid-operation:
  - The sweep restarts from register 0.
  - `pending` clears, the pointer returns to requester 0, and any in-flight grant is lost.

## Timing
- Reset values: `WS`=0, `regW`=0, `dataW`=0, `pending`=0, `init_done`=0, `req*_ready`=0.
- INIT writes start at the first posedge after `rst` falls and last exactly NREG cycles. `init_done` rises on the posedge that registers the final sweep write.
- Grant latency:
  - Grant in cycle t; `WS`/`regW`/`dataW` valid during cycle t+1.
  - The register file commits on the negedge inside t+1.
  - The hazard bit drops at the start of t+1; consumers must sample read data at the posedge that ends t+1.
- Throughput: one write per cycle. With both requesters always valid, grants alternate 0,1,0,1.
- `hazardA`/`hazardB` are combinational from `regA`/`regB`: no registered latency.

## Structure
- Package `regfile_ctrl_pkg` holds `DATA_W`, `ADDR_W`, `NREG` defaults and the state typedef `st_e` {ST_INIT, ST_RUN}.
- One sub-module, `rr_arb2`: a 2-way round-robin arbiter with req[1:0], gnt[1:0] and an internal last-grant pointer.
- The scoreboard, sweep counter and output registers live in the top level.

## Test plan
- Release reset, hold `req0_valid`=1 → `req0_ready`=0 for 32 cycles; `WS`=1 with `regW`=0..31 and `dataW`=0; `init_done` rises; `req0_ready` rises the next cycle.
- RUN, `req0` (reg 3, 0xDEADBEEF) alone → `req0_ready`=1 that cycle; next cycle `WS`=1, `regW`=3, `dataW`=0xDEADBEEF; a read of reg 3 returns 0xDEADBEEF one cycle later.
- Both valid for 4 cycles (req0: reg 1, req1: reg 2) → grants 0,1,0,1; `regW` sequence 1,2,1,2.
- `rsv_valid` reg 5, then `regA`=5 → `hazardA`=1 until req1 writes reg 5; drops the cycle `WS`=1, `regW`=5. A same-cycle reserve and grant for reg 5 leaves `hazardA`=1.
- `req1` writes reg 0 with 0xFFFFFFFF → handshake completes; `WS` stays 0; `pending[0]`=0; the pointer still advances.
- Assert `rst` at sweep count 17 → outputs return to reset values immediately; after release, the sweep restarts at `regW`=0 and runs the full 32 cycles.
